// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM encodings and direction-mask helpers for the
// PS/2 keyboard receiver and key decoder.
package ps2_pkg;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] ARROW_UP    = 8'h75;
    localparam logic [7:0] ARROW_DOWN  = 8'h72;
    localparam logic [7:0] ARROW_RIGHT = 8'h74;
    localparam logic [7:0] ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] WASD_UP     = 8'h1D;
    localparam logic [7:0] WASD_DOWN   = 8'h1B;
    localparam logic [7:0] WASD_RIGHT  = 8'h23;
    localparam logic [7:0] WASD_LEFT   = 8'h1C;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rxState_t;
    typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} decState_t;

    // Direction masks use the uBtns bit order: [3] up, [2] down, [1] right, [0] left.
    function automatic logic [3:0] arrowMask(input logic [7:0] code);
        case (code)
            ARROW_UP:    arrowMask = 4'b1000;
            ARROW_DOWN:  arrowMask = 4'b0100;
            ARROW_RIGHT: arrowMask = 4'b0010;
            ARROW_LEFT:  arrowMask = 4'b0001;
            default:     arrowMask = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] wasdMask(input logic [7:0] code);
        case (code)
            WASD_UP:    wasdMask = 4'b1000;
            WASD_DOWN:  wasdMask = 4'b0100;
            WASD_RIGHT: wasdMask = 4'b0010;
            WASD_LEFT:  wasdMask = 4'b0001;
            default:    wasdMask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, PS2_CLK glitch filter, inactivity timeout
// and the start/data/parity/stop receive FSM.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxByte,
    output logic       byteValid,
    output logic       err,
    output rxState_t   state
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clkS1, clkS2, datS1, datS2, clkFilt, edgeAcc;
    logic [FW-1:0] filtCnt;
    logic [TW-1:0] toCnt, toCntNext;
    logic [2:0]    bitCnt, bitCntNext;
    logic [7:0]    shift, shiftNext, byteNext;
    logic          parityBit, parityNext, validNext, errNext;
    rxState_t      stateNext;

    // The filtered level resets low, so a full run of high samples is needed
    // before any falling edge can be accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clkS1   <= 1'b0;
            clkS2   <= 1'b0;
            datS1   <= 1'b0;
            datS2   <= 1'b0;
            clkFilt <= 1'b0;
            filtCnt <= '0;
        end else begin
            clkS1 <= ps2Clk;
            clkS2 <= clkS1;
            datS1 <= ps2Data;
            datS2 <= datS1;
            if (clkS2 == clkFilt) begin
                filtCnt <= '0;
            end else if (filtCnt == FW'(FILTER_LEN - 1)) begin
                clkFilt <= clkS2;
                filtCnt <= '0;
            end else begin
                filtCnt <= filtCnt + FW'(1);
            end
        end
    end

    assign edgeAcc = clkFilt && !clkS2 && (filtCnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RX_IDLE;
            bitCnt    <= '0;
            shift     <= '0;
            parityBit <= 1'b0;
            rxByte    <= '0;
            byteValid <= 1'b0;
            err       <= 1'b0;
            toCnt     <= '0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shift     <= shiftNext;
            parityBit <= parityNext;
            rxByte    <= byteNext;
            byteValid <= validNext;
            err       <= errNext;
            toCnt     <= toCntNext;
        end
    end

    // byteValid and err are single-cycle strobes with no ready: the consumer
    // must take rxByte in the cycle byteValid is high. They never coincide.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shift;
        parityNext = parityBit;
        byteNext   = rxByte;
        validNext  = 1'b0;
        errNext    = 1'b0;
        toCntNext  = (state == RX_IDLE) ? '0 : toCnt + TW'(1);
        if (edgeAcc) begin
            toCntNext = '0;
            case (state)
                RX_IDLE: begin
                    if (datS2) begin
                        errNext = 1'b1;
                    end else begin
                        stateNext  = RX_DATA;
                        bitCntNext = '0;
                    end
                end
                RX_DATA: begin
                    shiftNext = {datS2, shift[7:1]};
                    if (bitCnt == 3'd7) stateNext = RX_PARITY;
                    else bitCntNext = bitCnt + 3'd1;
                end
                RX_PARITY: begin
                    parityNext = datS2;
                    stateNext  = RX_STOP;
                end
                RX_STOP: begin
                    stateNext  = RX_IDLE;
                    bitCntNext = '0;
                    if (datS2 && (^{shift, parityBit})) begin
                        byteNext  = shift;
                        validNext = 1'b1;
                    end else begin
                        errNext = 1'b1;
                    end
                end
                default: stateNext = RX_IDLE;
            endcase
        end else if (state != RX_IDLE && toCnt == TW'(TIMEOUT_CYC - 1)) begin
            stateNext  = RX_IDLE;
            bitCntNext = '0;
            toCntNext  = '0;
            errNext    = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns received scan codes into held arrow/WASD
// directions, tracking E0 (extended) and F0 (break) prefixes.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [3:0] uBtns,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err,
    output rxState_t   rxStateDbg,
    output decState_t  decStateDbg
);
    decState_t  decState, decNext;
    logic [3:0] arrowHold, arrowNext, wasdHold, wasdNext;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2Clk   (PS2_CLK),
        .ps2Data  (PS2_DATA),
        .rxByte   (scan_code),
        .byteValid(code_valid),
        .err      (frame_err),
        .state    (rxStateDbg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            decState  <= DEC_BASE;
            arrowHold <= '0;
            wasdHold  <= '0;
            uBtns     <= '0;
        end else begin
            decState  <= decNext;
            arrowHold <= arrowNext;
            wasdHold  <= wasdNext;
            uBtns     <= arrowNext | wasdNext;
        end
    end

    // Arrow and WASD holds are kept apart so releasing one key set leaves a
    // direction still held by the other.
    always_comb begin
        decNext   = decState;
        arrowNext = arrowHold;
        wasdNext  = wasdHold;
        if (code_valid) begin
            decNext = DEC_BASE;
            case (decState)
                DEC_BASE: begin
                    if (scan_code == CODE_EXT) decNext = DEC_EXT;
                    else if (scan_code == CODE_BRK) decNext = DEC_BRK;
                    else wasdNext = wasdHold | wasdMask(scan_code);
                end
                DEC_EXT: begin
                    if (scan_code == CODE_BRK) decNext = DEC_EXT_BRK;
                    else if (scan_code == CODE_EXT) decNext = DEC_EXT;
                    else arrowNext = arrowHold | arrowMask(scan_code);
                end
                DEC_BRK:     wasdNext  = wasdHold & ~wasdMask(scan_code);
                DEC_EXT_BRK: arrowNext = arrowHold & ~arrowMask(scan_code);
                default:     decNext   = DEC_BASE;
            endcase
        end
    end

    assign decStateDbg = decState;

endmodule
